// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bus_arbiter
//  Description : Shares one SRAM port between CPU (0), VGA (1) and UART (2).
//                VGA has absolute priority. While VGA is active or about to
//                be, the CPU and UART are held off. CPU and UART otherwise
//                share the port round-robin. Each transaction runs
//                IDLE -> ISSUE -> WAIT -> DONE with a busy timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_bus_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [1:0]    vga_state,
  input  logic          cpu_req,
  input  logic          vga_req,
  input  logic          uart_req,
  input  logic          cpu_we,
  input  logic          uart_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [AW-1:0] vga_addr,
  input  logic [AW-1:0] uart_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic [31:0]   uart_wdata,
  input  logic [3:0]    cpu_sel,
  input  logic [3:0]    vga_sel,
  input  logic [3:0]    uart_sel,
  output logic          cpu_ack,
  output logic          vga_ack,
  output logic          uart_ack,
  output logic          cpu_err,
  output logic          uart_err,
  output logic [31:0]   rdata,
  output logic [1:0]    current_client,
  output logic          sram_read,
  output logic          sram_write,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  output logic [3:0]    sram_sel,
  input  logic          sram_busy,
  input  logic [31:0]   sram_rdata
);

  localparam int         c_cw      = $clog2(TIMEOUT + 1);
  localparam logic [1:0] c_id_cpu  = 2'd0;
  localparam logic [1:0] c_id_vga  = 2'd1;
  localparam logic [1:0] c_id_uart = 2'd2;
  localparam logic [1:0] c_id_none = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_we;
  logic              r_prefer_uart;
  logic [c_cw-1:0]   r_cnt;

  logic              w_hold_off;
  logic              w_gnt_vga;
  logic              w_gnt_cpu;
  logic              w_gnt_uart;

  // Grant decision for the current IDLE cycle: VGA first, then round-robin.
  always_comb begin
    w_hold_off = (vga_state == 2'd1) || (vga_state == 2'd2);
    w_gnt_vga  = vga_req;
    w_gnt_cpu  = !vga_req && !w_hold_off && cpu_req  && (!uart_req || !r_prefer_uart);
    w_gnt_uart = !vga_req && !w_hold_off && uart_req && (!cpu_req  ||  r_prefer_uart);
  end

  // Transaction sequencer; every output is registered here.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state        <= S_IDLE;
      r_we           <= 1'b0;
      r_prefer_uart  <= 1'b0;
      r_cnt          <= '0;
      cpu_ack        <= 1'b0;
      vga_ack        <= 1'b0;
      uart_ack       <= 1'b0;
      cpu_err        <= 1'b0;
      uart_err       <= 1'b0;
      rdata          <= '0;
      current_client <= c_id_none;
      sram_read      <= 1'b0;
      sram_write     <= 1'b0;
      sram_addr      <= '0;
      sram_wdata     <= '0;
      sram_sel       <= '0;
    end else begin
      // Pulses default low; they are raised for exactly one cycle below.
      cpu_ack    <= 1'b0;
      vga_ack    <= 1'b0;
      uart_ack   <= 1'b0;
      cpu_err    <= 1'b0;
      uart_err   <= 1'b0;
      sram_read  <= 1'b0;
      sram_write <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_gnt_vga) begin
            current_client <= c_id_vga;
            sram_addr      <= vga_addr;
            sram_wdata     <= '0;
            sram_sel       <= vga_sel;
            r_we           <= 1'b0;
            sram_read      <= 1'b1;
            r_state        <= S_ISSUE;
          end else if (w_gnt_cpu) begin
            current_client <= c_id_cpu;
            sram_addr      <= cpu_addr;
            sram_wdata     <= cpu_wdata;
            sram_sel       <= cpu_sel;
            r_we           <= cpu_we;
            sram_read      <= !cpu_we;
            sram_write     <= cpu_we;
            r_prefer_uart  <= 1'b1;
            r_state        <= S_ISSUE;
          end else if (w_gnt_uart) begin
            current_client <= c_id_uart;
            sram_addr      <= uart_addr;
            sram_wdata     <= uart_wdata;
            sram_sel       <= uart_sel;
            r_we           <= uart_we;
            sram_read      <= !uart_we;
            sram_write     <= uart_we;
            r_prefer_uart  <= 1'b0;
            r_state        <= S_ISSUE;
          end
        end

        // Strobe is visible during this cycle; arm the busy timeout.
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (!sram_busy) begin
            if (!r_we) begin
              rdata <= sram_rdata;
            end
            case (current_client)
              c_id_cpu: cpu_ack  <= 1'b1;
              c_id_vga: vga_ack  <= 1'b1;
              default:  uart_ack <= 1'b1;
            endcase
            r_state <= S_DONE;
          end else if (r_cnt == c_cw'(TIMEOUT - 1)) begin
            // VGA has no error line, so its timeout completes as a plain ack.
            case (current_client)
              c_id_cpu: cpu_err  <= 1'b1;
              c_id_vga: vga_ack  <= 1'b1;
              default:  uart_err <= 1'b1;
            endcase
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Response pulse is visible during this cycle; release the bus.
        default: begin
          current_client <= c_id_none;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_bus_arbiter
//  Description : Scoreboard bench for sram_bus_arbiter. It holds the expected
//                completions in grant order, and a behavioural SRAM with
//                programmable busy length.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic [1:0]  vga_state;
  logic        cpu_req, vga_req, uart_req;
  logic        cpu_we, uart_we;
  logic [31:0] cpu_addr, vga_addr, uart_addr;
  logic [31:0] cpu_wdata, uart_wdata;
  logic [3:0]  cpu_sel, vga_sel, uart_sel;
  logic        cpu_ack, vga_ack, uart_ack, cpu_err, uart_err;
  logic [31:0] rdata;
  logic [1:0]  current_client;
  logic        sram_read, sram_write;
  logic [31:0] sram_addr, sram_wdata;
  logic [3:0]  sram_sel;
  logic        sram_busy;
  logic [31:0] sram_rdata;

  sram_bus_arbiter #(.TIMEOUT(64), .AW(32)) dut (
    .clk(clk), .nrst(nrst), .vga_state(vga_state),
    .cpu_req(cpu_req), .vga_req(vga_req), .uart_req(uart_req),
    .cpu_we(cpu_we), .uart_we(uart_we),
    .cpu_addr(cpu_addr), .vga_addr(vga_addr), .uart_addr(uart_addr),
    .cpu_wdata(cpu_wdata), .uart_wdata(uart_wdata),
    .cpu_sel(cpu_sel), .vga_sel(vga_sel), .uart_sel(uart_sel),
    .cpu_ack(cpu_ack), .vga_ack(vga_ack), .uart_ack(uart_ack),
    .cpu_err(cpu_err), .uart_err(uart_err),
    .rdata(rdata), .current_client(current_client),
    .sram_read(sram_read), .sram_write(sram_write),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_sel(sram_sel),
    .sram_busy(sram_busy), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          ack_log[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ack_cyc = 0;
  int          t0 = 0;
  int          cpu_left = 0;
  int          uart_left = 0;
  int          sram_lat = 0;
  int          sram_left = 0;
  logic [31:0] last_rdata = '0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic exp_t mk(input logic [1:0] id, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] sel, input logic err);
    exp_t e;
    e.id = id; e.we = we; e.addr = addr; e.wdata = wdata; e.sel = sel; e.err = err;
    return e;
  endfunction

  // One clock: check responses, advance clients, then run the SRAM model.
  task automatic step();
    int          n;
    logic [1:0]  id;
    logic        er;
    logic [31:0] exp_rd;
    exp_t        e;
    @(negedge clk);
    cyc++;
    if ((sram_read || sram_write) && sb.size() != 0) begin
      e = sb[0];
      check_val("strobe_excl", {1'b0, sram_read & sram_write}, 0);
      check_val("strobe_write", {1'b0, sram_write}, {1'b0, e.we});
      check_val("strobe_addr", sram_addr, e.addr);
      check_val("strobe_sel", sram_sel, e.sel);
      if (e.we) check_val("strobe_wdata", sram_wdata, e.wdata);
    end
    n = int'(cpu_ack) + int'(vga_ack) + int'(uart_ack) + int'(cpu_err) + int'(uart_err);
    if (n != 0) begin
      check_val("one_resp", n, 1);
      id = cpu_ack || cpu_err ? 2'd0 : (vga_ack ? 2'd1 : 2'd2);
      er = cpu_err | uart_err;
      ack_cyc = cyc;
      ack_log.push_back(cyc);
      if (sb.size() == 0) begin
        check_val("unexp_resp", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check_val("resp_id", id, e.id);
        check_val("resp_err", {1'b0, er}, {1'b0, e.err});
        check_val("cc_done", current_client, e.id);
        exp_rd = (e.we || e.err) ? last_rdata : mem_fn(e.addr);
        last_rdata = exp_rd;
        check_val("rdata", rdata, exp_rd);
      end
    end
    if (cpu_ack || cpu_err) begin
      if (cpu_left > 0) begin cpu_left--; cpu_addr = cpu_addr + 1; end
      else cpu_req = 1'b0;
    end
    if (uart_ack || uart_err) begin
      if (uart_left > 0) begin uart_left--; uart_addr = uart_addr + 1; end
      else uart_req = 1'b0;
    end
    if (vga_ack) vga_req = 1'b0;
    if (!nrst) begin
      sram_busy = 1'b0;
      sram_left = 0;
    end else if (sram_read || sram_write) begin
      sram_left  = sram_lat;
      sram_busy  = (sram_lat > 0);
      sram_rdata = mem_fn(sram_addr);
    end else if (sram_left > 0) begin
      sram_left--;
      if (sram_left == 0) sram_busy = 1'b0;
    end
  endtask

  task automatic run_until_empty(input int max);
    for (int i = 0; i < max && sb.size() != 0; i++) step();
    check_val("drain", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; vga_state = 2'd0;
    cpu_req = 0; vga_req = 0; uart_req = 0; cpu_we = 0; uart_we = 0;
    cpu_addr = 0; vga_addr = 0; uart_addr = 0; cpu_wdata = 0; uart_wdata = 0;
    cpu_sel = 4'hF; vga_sel = 4'hF; uart_sel = 4'hF;
    sram_busy = 1'b0; sram_rdata = '0;
    step(); step();
    check_val("rst_cc", current_client, 3);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_addr", sram_addr, 0);
    check_val("rst_wdata", sram_wdata, 0);
    check_val("rst_sel", sram_sel, 0);
    check_val("rst_pulses", {cpu_ack, vga_ack, uart_ack, cpu_err, uart_err, sram_read, sram_write}, 0);
    nrst = 1'b1;
    step();

    // CPU and UART both requesting continuously: strict alternation, 4 cycles apart.
    cpu_addr = 32'h200; cpu_we = 0; cpu_sel = 4'hF; cpu_left = 1;
    uart_addr = 32'h300; uart_we = 1; uart_wdata = 32'h1234_5678; uart_sel = 4'h3; uart_left = 1;
    sb.push_back(mk(0, 0, 32'h200, 0, 4'hF, 0));
    sb.push_back(mk(2, 1, 32'h300, 32'h1234_5678, 4'h3, 0));
    sb.push_back(mk(0, 0, 32'h201, 0, 4'hF, 0));
    sb.push_back(mk(2, 1, 32'h301, 32'h1234_5678, 4'h3, 0));
    ack_log.delete();
    cpu_req = 1; uart_req = 1; t0 = cyc;
    run_until_empty(40);
    check_val("rr_count", ack_log.size(), 4);
    if (ack_log.size() == 4) begin
      check_val("min_latency", ack_log[0] - t0, 3);
      for (int i = 0; i < 3; i++) check_val("rr_spacing", ack_log[i+1] - ack_log[i], 4);
    end
    step();

    // Single CPU read of 0x100 with a slow SRAM.
    sram_lat = 3; cpu_addr = 32'h100; cpu_we = 0; cpu_left = 0;
    sb.push_back(mk(0, 0, 32'h100, 0, 4'hF, 0));
    cpu_req = 1;
    step();
    check_val("cc_grant", current_client, 0);
    run_until_empty(40);
    check_val("rdata_beef", rdata, 32'hDEAD_BEEF);
    step();
    check_val("cc_release", current_client, 3);

    // VGA about to be active blocks the CPU; VGA itself still gets through.
    sram_lat = 0; vga_state = 2'd1; cpu_addr = 32'h400;
    sb.push_back(mk(0, 0, 32'h400, 0, 4'hF, 0));
    cpu_req = 1;
    repeat (6) step();
    check_val("blocked_cc", current_client, 3);
    check_val("blocked_pending", sb.size(), 1);
    vga_addr = 32'h3E80; vga_sel = 4'hF;
    sb.push_front(mk(1, 0, 32'h3E80, 0, 4'hF, 0));
    vga_req = 1;
    repeat (8) step();
    check_val("vga_first", sb.size(), 1);
    vga_state = 2'd2;
    repeat (3) step();
    check_val("active_blocked", sb.size(), 1);
    vga_state = 2'd3;
    run_until_empty(20);
    step();

    // All three at once: VGA first even though the pointer now favours UART.
    vga_state = 2'd0;
    cpu_addr = 32'h500; uart_addr = 32'h600; uart_we = 0; vga_addr = 32'h700;
    sb.push_back(mk(1, 0, 32'h700, 0, 4'hF, 0));
    sb.push_back(mk(2, 0, 32'h600, 0, 4'h3, 0));
    sb.push_back(mk(0, 0, 32'h500, 0, 4'hF, 0));
    vga_req = 1; cpu_req = 1; uart_req = 1;
    run_until_empty(40);
    step();

    // UART write against a permanently busy SRAM times out with uart_err.
    sram_lat = 1000; uart_addr = 32'h800; uart_we = 1; uart_wdata = 32'hCAFE_F00D;
    sb.push_back(mk(2, 1, 32'h800, 32'hCAFE_F00D, 4'h3, 1));
    uart_req = 1; t0 = cyc;
    run_until_empty(100);
    check_val("timeout_latency", ack_cyc - t0, 66);
    step();

    // Reset in the middle of a CPU read: abandoned silently, pointer back to CPU.
    sram_lat = 10; cpu_addr = 32'h900; cpu_we = 0;
    sb.push_back(mk(0, 0, 32'h900, 0, 4'hF, 0));
    cpu_req = 1;
    step(); step(); step();
    nrst = 1'b0;
    #1;
    check_val("mid_rst_cc", current_client, 3);
    check_val("mid_rst_addr", sram_addr, 0);
    check_val("mid_rst_rdata", rdata, 0);
    check_val("mid_rst_pulses", {cpu_ack, vga_ack, uart_ack, cpu_err, uart_err, sram_read, sram_write}, 0);
    sb.delete();
    last_rdata = '0;
    sram_busy = 1'b0; sram_left = 0; sram_lat = 0;
    uart_addr = 32'hA00; uart_we = 0;
    sb.push_back(mk(0, 0, 32'h900, 0, 4'hF, 0));
    sb.push_back(mk(2, 0, 32'hA00, 0, 4'h3, 0));
    uart_req = 1;
    step(); step();
    nrst = 1'b1;
    run_until_empty(40);
    step();
    check_val("final_cc", current_client, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
